simon_sequencer: RTL and testbench



---
 rtl/simon_pkg.sv | 23 ++
 rtl/simon_lfsr.sv | 28 ++
 rtl/simon_sequencer.sv | 186 ++++++++++++++++++
 tb/tb_simon_sequencer.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/simon_pkg.sv
// Shared types and constants for the Simon sequencer: FSM state encoding and
// LFSR polynomial used to draw pad indices.
package simon_pkg;

    localparam int unsigned LfsrW = 16;
    localparam logic [LfsrW-1:0] LfsrMask = 16'hB400;

    typedef enum logic [2:0] {
        StIdle,
        StExtend,
        StShowOn,
        StShowOff,
        StInput,
        StFail,
        StWin
    } state_e;

    // One step of a right-shifting Galois LFSR.
    function automatic logic [LfsrW-1:0] lfsr_step(input logic [LfsrW-1:0] v);
        return (v >> 1) ^ (v[0] ? LfsrMask : '0);
    endfunction

endpackage

// File: rtl/simon_lfsr.sv
// Free-running 16-bit Galois LFSR; advances every cycle and reloads SEED on reset.
module simon_lfsr
    import simon_pkg::*;
#(
    parameter logic [LfsrW-1:0] SEED = 16'hACE1
) (
    input  logic             clk,
    input  logic             resetn,
    output logic [LfsrW-1:0] lfsr
);

    logic [LfsrW-1:0] lfsr_q, lfsr_d;

    always_comb begin
        lfsr_d = lfsr_step(lfsr_q);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            lfsr_q <= SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign lfsr = lfsr_q;

endmodule

// File: rtl/simon_sequencer.sv
// Simon game engine: grows a random pad sequence, plays it back, checks guesses and keeps score.
// Define SIMON_TIMEOUT_EN to fail a round when no guess arrives within TIMEOUT_CYCLES.
module simon_sequencer
    import simon_pkg::*;
#(
    parameter int unsigned   N_PADS         = 4,
    parameter int unsigned   MAX_LEN        = 16,
    parameter int unsigned   ON_CYCLES      = 10_000_000,
    parameter int unsigned   OFF_CYCLES     = 5_000_000,
    parameter int unsigned   TIMEOUT_CYCLES = 100_000_000,
    parameter logic [15:0]   SEED           = 16'hACE1,
    parameter int unsigned   SCORE_W        = 8,
    localparam int unsigned  IDX_W          = $clog2(N_PADS),
    localparam int unsigned  LEN_W          = $clog2(MAX_LEN + 1)
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               start,
    input  logic               guess_valid,
    input  logic [IDX_W-1:0]   guess,
    output logic [N_PADS-1:0]  pad_on,
    output logic               accept,
    output logic               busy,
    output logic [LEN_W-1:0]   round_len,
    output logic [SCORE_W-1:0] score,
    output logic [SCORE_W-1:0] high_score,
    output logic               game_over,
    output logic               win
);

    localparam int unsigned PtrW    = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam int unsigned ShowMax = (ON_CYCLES > OFF_CYCLES) ? ON_CYCLES : OFF_CYCLES;
`ifdef SIMON_TIMEOUT_EN
    localparam int unsigned TmrMax  = (ShowMax > TIMEOUT_CYCLES) ? ShowMax : TIMEOUT_CYCLES;
`else
    localparam int unsigned TmrMax  = ShowMax;
    localparam int unsigned unused_timeout = TIMEOUT_CYCLES;
`endif
    localparam int unsigned TmrW    = $clog2(TmrMax + 1);

    state_e                state_q, state_d;
    logic [IDX_W-1:0]      seq_q [MAX_LEN];
    logic [IDX_W-1:0]      seq_d [MAX_LEN];
    logic [LEN_W-1:0]      round_len_q, round_len_d;
    logic [PtrW-1:0]       play_idx_q, play_idx_d;
    logic [PtrW-1:0]       in_idx_q, in_idx_d;
    logic [TmrW-1:0]       timer_q, timer_d;
    logic [SCORE_W-1:0]    score_q, score_d;
    logic [SCORE_W-1:0]    high_score_q, high_score_d;
    logic [LfsrW-1:0]      lfsr;
    logic                  unused_lfsr;

    simon_lfsr #(
        .SEED (SEED)
    ) u_lfsr (
        .clk    (clk),
        .resetn (resetn),
        .lfsr   (lfsr)
    );

    assign unused_lfsr = ^lfsr[LfsrW-1:IDX_W];

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q      <= StIdle;
            seq_q        <= '{default: '0};
            round_len_q  <= '0;
            play_idx_q   <= '0;
            in_idx_q     <= '0;
            timer_q      <= '0;
            score_q      <= '0;
            high_score_q <= '0;
        end else begin
            state_q      <= state_d;
            seq_q        <= seq_d;
            round_len_q  <= round_len_d;
            play_idx_q   <= play_idx_d;
            in_idx_q     <= in_idx_d;
            timer_q      <= timer_d;
            score_q      <= score_d;
            high_score_q <= high_score_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        seq_d        = seq_q;
        round_len_d  = round_len_q;
        play_idx_d   = play_idx_q;
        in_idx_d     = in_idx_q;
        timer_d      = timer_q;
        score_d      = score_q;
        high_score_d = high_score_q;

        case (state_q)
            StIdle: begin
                if (start) begin
                    round_len_d = '0;
                    score_d     = '0;
                    state_d     = StExtend;
                end
            end
            StExtend: begin
                seq_d[PtrW'(round_len_q)] = lfsr[IDX_W-1:0];
                round_len_d = round_len_q + LEN_W'(1);
                play_idx_d  = '0;
                timer_d     = TmrW'(ON_CYCLES - 1);
                state_d     = StShowOn;
            end
            StShowOn: begin
                if (timer_q == '0) begin
                    timer_d = TmrW'(OFF_CYCLES - 1);
                    state_d = StShowOff;
                end else begin
                    timer_d = timer_q - TmrW'(1);
                end
            end
            StShowOff: begin
                if (timer_q == '0) begin
                    play_idx_d = play_idx_q + PtrW'(1);
                    if (LEN_W'(play_idx_q) + LEN_W'(1) == round_len_q) begin
                        in_idx_d = '0;
`ifdef SIMON_TIMEOUT_EN
                        timer_d  = TmrW'(TIMEOUT_CYCLES - 1);
`endif
                        state_d  = StInput;
                    end else begin
                        timer_d = TmrW'(ON_CYCLES - 1);
                        state_d = StShowOn;
                    end
                end else begin
                    timer_d = timer_q - TmrW'(1);
                end
            end
            StInput: begin
                // A guess arriving on the expiry cycle wins over the timeout.
                if (guess_valid) begin
                    if (guess != seq_q[in_idx_q]) begin
                        state_d = StFail;
                    end else if (LEN_W'(in_idx_q) + LEN_W'(1) != round_len_q) begin
                        in_idx_d = in_idx_q + PtrW'(1);
`ifdef SIMON_TIMEOUT_EN
                        timer_d  = TmrW'(TIMEOUT_CYCLES - 1);
`endif
                    end else begin
                        score_d = score_q + SCORE_W'(1);
                        state_d = (round_len_q == LEN_W'(MAX_LEN)) ? StWin : StExtend;
                    end
`ifdef SIMON_TIMEOUT_EN
                end else if (timer_q == '0) begin
                    state_d = StFail;
                end else begin
                    timer_d = timer_q - TmrW'(1);
`endif
                end
            end
            StFail, StWin: begin
                if (score_q > high_score_q) begin
                    high_score_d = score_q;
                end
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        pad_on    = '0;
        accept    = 1'b0;
        busy      = (state_q != StIdle);
        game_over = 1'b0;
        win       = 1'b0;
        case (state_q)
            StShowOn: pad_on    = N_PADS'(1) << seq_q[play_idx_q];
            StInput:  accept    = 1'b1;
            StFail:   game_over = 1'b1;
            StWin:    win       = 1'b1;
            default:  ;
        endcase
    end

    assign round_len  = round_len_q;
    assign score      = score_q;
    assign high_score = high_score_q;

endmodule

// File: tb/tb_simon_sequencer.sv
// Directed bench for simon_sequencer (4 pads, 3-step game, short timers).
module tb_simon_sequencer;

    localparam int unsigned NP  = 4;
    localparam int unsigned ML  = 3;
    localparam int unsigned ON  = 4;
    localparam int unsigned OFF = 2;
    localparam int unsigned TO  = 20;
    localparam logic [15:0] SEED = 16'hACE1;

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic       start = 1'b0;
    logic       guess_valid = 1'b0;
    logic [1:0] guess = 2'd0;
    logic [3:0] pad_on;
    logic       accept, busy, game_over, win;
    logic [1:0] round_len;
    logic [7:0] score, high_score;

    simon_sequencer #(
        .N_PADS         (NP),
        .MAX_LEN        (ML),
        .ON_CYCLES      (ON),
        .OFF_CYCLES     (OFF),
        .TIMEOUT_CYCLES (TO),
        .SEED           (SEED),
        .SCORE_W        (8)
    ) dut (
        .clk         (clk),
        .resetn      (resetn),
        .start       (start),
        .guess_valid (guess_valid),
        .guess       (guess),
        .pad_on      (pad_on),
        .accept      (accept),
        .busy        (busy),
        .round_len   (round_len),
        .score       (score),
        .high_score  (high_score),
        .game_over   (game_over),
        .win         (win)
    );

    always #5 clk = ~clk;

    // Reference LFSR tracking the value the DUT will sample in EXTEND.
    logic [15:0] model_q;
    always @(posedge clk or negedge resetn) begin
        if (!resetn) model_q <= SEED;
        else         model_q <= (model_q >> 1) ^ (model_q[0] ? 16'hB400 : 16'h0000);
    end

    int checks = 0;
    int failures = 0;
    logic [1:0] exp_seq [3];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic start_game;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Entered in the EXTEND cycle; returns in the first INPUT cycle.
    task automatic play_round(input int r);
        logic [3:0] lit;
        exp_seq[r-1] = model_q[1:0];
        check("extend_busy", 32'(busy), 1);
        check("extend_dark", 32'(pad_on), 0);
        for (int k = 0; k < r; k++) begin
            lit = 4'b0001 << exp_seq[k];
            for (int c = 0; c < int'(ON); c++) begin
                tick();
                check("pad_lit", 32'(pad_on), 32'(lit));
                check("show_no_accept", 32'(accept), 0);
            end
            for (int c = 0; c < int'(OFF); c++) begin
                tick();
                check("pad_dark", 32'(pad_on), 0);
                check("gap_no_accept", 32'(accept), 0);
            end
        end
        tick();
        check("accept_rise", 32'(accept), 1);
        check("round_len", 32'(round_len), 32'(r));
    endtask

    // Echo the sequence; a negative wrong_at means every guess is correct.
    task automatic echo(input int r, input int wrong_at);
        for (int k = 0; k < r; k++) begin
            guess = (k == wrong_at) ? exp_seq[k] + 2'd1 : exp_seq[k];
            guess_valid = 1'b1;
            tick();
            guess_valid = 1'b0;
            if (k == wrong_at) return;
            if (k < r - 1) check("mid_accept", 32'(accept), 1);
        end
    endtask

    initial begin
        repeat (2) tick();
        resetn = 1'b1;

        // Idle with a stray guess that must be ignored.
        for (int i = 0; i < 50; i++) begin
            guess_valid = (i == 10);
            tick();
        end
        guess_valid = 1'b0;
        check("rst_pad", 32'(pad_on), 0);
        check("rst_accept", 32'(accept), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_score", 32'(score), 0);
        check("rst_high", 32'(high_score), 0);
        check("rst_len", 32'(round_len), 0);

        // Full winning game.
        start_game();
        play_round(1);
        echo(1, -1);
        check("r1_score", 32'(score), 1);
        check("r1_extend", 32'(busy), 1);
        play_round(2);
        echo(2, -1);
        check("r2_score", 32'(score), 2);
        play_round(3);
        echo(3, -1);
        check("win_pulse", 32'(win), 1);
        check("win_score", 32'(score), 3);
        check("win_high_lag", 32'(high_score), 0);
        tick();
        check("win_once", 32'(win), 0);
        check("win_high", 32'(high_score), 3);
        check("win_idle", 32'(busy), 0);
        check("win_keep_score", 32'(score), 3);

        // Wrong guess at step 0 of round 2.
        start_game();
        check("restart_score", 32'(score), 0);
        play_round(1);
        echo(1, -1);
        play_round(2);
        echo(2, 0);
        check("fail_pulse", 32'(game_over), 1);
        check("fail_score", 32'(score), 1);
        tick();
        check("fail_once", 32'(game_over), 0);
        check("fail_high", 32'(high_score), 3);
        check("fail_idle", 32'(busy), 0);

        // Asynchronous reset in the middle of SHOW_ON.
        start_game();
        tick();
        tick();
        check("pre_rst_lit", 32'(pad_on != 4'd0), 1);
        check("pre_rst_len", 32'(round_len), 1);
        #2 resetn = 1'b0;
        #1;
        check("arst_pad", 32'(pad_on), 0);
        check("arst_len", 32'(round_len), 0);
        check("arst_score", 32'(score), 0);
        check("arst_high", 32'(high_score), 0);
        check("arst_busy", 32'(busy), 0);
        check("arst_lfsr", 32'(dut.u_lfsr.lfsr_q), 32'(SEED));
        @(negedge clk);
        resetn = 1'b1;
        tick();

        // Input timeout behaviour.
        start_game();
        play_round(1);
`ifdef SIMON_TIMEOUT_EN
        begin
            int early = 0;
            for (int i = 1; i < int'(TO); i++) begin
                tick();
                if (game_over) early++;
            end
            check("to_early", 32'(early), 0);
            tick();
            check("to_fire", 32'(game_over), 1);
            check("to_score", 32'(score), 0);
            tick();
            check("to_idle", 32'(busy), 0);
        end
`else
        begin
            int drops = 0;
            repeat (1000) begin
                tick();
                if (!accept) drops++;
            end
            check("wait_drops", 32'(drops), 0);
            check("wait_accept", 32'(accept), 1);
            @(negedge clk);
            resetn = 1'b0;
            @(negedge clk);
            resetn = 1'b1;
            tick();
        end
`endif

        // Fresh high score from a one-round game, failing at step 1 of round 2.
        start_game();
        play_round(1);
        echo(1, -1);
        play_round(2);
        echo(2, 1);
        check("fail2_pulse", 32'(game_over), 1);
        check("fail2_score", 32'(score), 1);
        tick();
        check("fail2_high", 32'(high_score), 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
